// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: decode control, instruction memory handshake and fetch status.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] fetch_pc;
    logic            timeout_err;
    logic            misalign_err;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_pc,
               timeout_err, misalign_err
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_pc,
               timeout_err, misalign_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one memory request in
// flight, drops responses made stale by a redirect, holds the fetched
// instruction while decode stalls and reissues after a lost response.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    logic              discard_reg, discard_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              valid_reg, valid_next;
    logic [31:0]       instr_reg, instr_next;
    logic [XLEN-1:0]   ifpc_reg, ifpc_next;
    logic              tmo_reg, tmo_next;
    logic              mis_reg, mis_next;
    logic              req;
    logic [XLEN-1:0]   redirect_aligned;
    logic              wait_expired;

    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
    // True in the last WAIT cycle that may still see a response before giving up.
    assign wait_expired     = (cnt_reg == CNT_W'(MAX_WAIT - 1));

    // Next-state, datapath and request decode; redirect always takes priority.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        discard_next = discard_reg;
        cnt_next     = cnt_reg;
        valid_next   = valid_reg;
        instr_next   = instr_reg;
        ifpc_next    = ifpc_reg;
        tmo_next     = tmo_reg;
        mis_next     = mis_reg;
        req          = 1'b0;

        if (bus.redirect_valid) begin
            pc_next = redirect_aligned;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                mis_next = 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                req = 1'b1;
                if (bus.imem_ready) begin
                    // A redirect in the accept cycle still launches the old
                    // address; its response must then be thrown away.
                    state_next   = WAIT;
                    cnt_next     = '0;
                    discard_next = bus.redirect_valid;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bus.redirect_valid) begin
                    // If the response (or the timeout) coincides with the
                    // redirect there is nothing left to wait for: go straight
                    // to the new PC. A redirect wins over the timeout, so no
                    // error is flagged in that case.
                    if (bus.imem_rvalid || wait_expired) begin
                        state_next   = REQ;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    state_next   = discard_reg ? REQ : HOLD;
                    discard_next = 1'b0;
                    if (!discard_reg) begin
                        valid_next = 1'b1;
                        instr_next = bus.imem_rdata;
                        ifpc_next  = pc_reg;
                    end
                end else if (wait_expired) begin
                    state_next   = REQ;
                    tmo_next     = 1'b1;
                    discard_next = 1'b0;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    state_next = REQ;
                    valid_next = 1'b0;
                end else if (!bus.stall) begin
                    state_next = REQ;
                    valid_next = 1'b0;
                    pc_next    = ifpc_reg + XLEN'(4);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            discard_reg <= 1'b0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            instr_reg   <= '0;
            ifpc_reg    <= '0;
            tmo_reg     <= 1'b0;
            mis_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            discard_reg <= discard_next;
            cnt_reg     <= cnt_next;
            valid_reg   <= valid_next;
            instr_reg   <= instr_next;
            ifpc_reg    <= ifpc_next;
            tmo_reg     <= tmo_next;
            mis_reg     <= mis_next;
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc_reg;
    assign bus.fetch_pc     = pc_reg;
    assign bus.if_valid     = valid_reg;
    assign bus.if_instr     = instr_reg;
    assign bus.if_pc        = ifpc_reg;
    assign bus.timeout_err  = tmo_reg;
    assign bus.misalign_err = mis_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized run
// against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.XLEN(XLEN)) bus();

    fetch_sequencer #(
        .XLEN(XLEN),
        .RESET_PC('0),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.fetch_pc !== 32'h0) begin bad++; $display("FAIL reset_fetch_pc got=%h want=%h", bus.fetch_pc, 32'h0); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", bus.if_valid); end
        total++; if (bus.if_instr !== 32'h0) begin bad++; $display("FAIL reset_if_instr got=%h want=0", bus.if_instr); end
        total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", bus.if_pc); end
        total++; if (bus.timeout_err !== 1'b0 || bus.misalign_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b want=00", bus.timeout_err, bus.misalign_err); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
        reset = 1'b0;
    endtask

    // Two back-to-back fetches from reset; ends in HOLD with 0x4.
    task automatic test_sequential();
        logic [31:0] a;
        bus.imem_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            a = 32'(4 * i);
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin bad++; $display("FAIL seq_req%0d got=%b/%h want=1/%h", i, bus.imem_req, bus.imem_addr, a); end
            tick();
            total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL seq_wait_req%0d got=%b want=0", i, bus.imem_req); end
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(a);
            tick();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== a || bus.if_instr !== mem_word(a)) begin bad++; $display("FAIL seq_deliver%0d got=%b/%h/%h want=1/%h/%h", i, bus.if_valid, bus.if_pc, bus.if_instr, a, mem_word(a)); end
            if (i == 0) tick();
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.if_valid !== 1'b1 || bus.if_instr !== mem_word(32'h4) || bus.if_pc !== 32'h4 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%h req=%b want=1/%h/4 req=0", k, bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_req, mem_word(32'h4)); end
        end
        bus.stall = 1'b0;
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b/%h/v%b want=1/8/v0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    endtask

    task automatic test_redirect_wait();
        bus.imem_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        total++; if (bus.fetch_pc !== 32'h100 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rdw_pc got=%h req=%b want=100 req=0", bus.fetch_pc, bus.imem_req); end
        tick();
        total++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rdw_still_wait got=v%b req=%b want=v0 req=0", bus.if_valid, bus.imem_req); end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h8);
        tick();
        bus.imem_rvalid = 1'b0;
        total++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_drop got=v%b/%b/%h want=v0/1/100", bus.if_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_rvalid_hold();
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_rvalid    = 1'b1;
        bus.imem_rdata     = mem_word(32'h100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.imem_rvalid    = 1'b0;
        bus.redirect_valid = 1'b0;
        total++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin bad++; $display("FAIL rdr_same_cycle got=v%b/%b/%h want=v0/1/200", bus.if_valid, bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h200);
        tick();
        bus.imem_rvalid = 1'b0;
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_instr !== mem_word(32'h200)) begin bad++; $display("FAIL rdr_deliver got=%b/%h/%h want=1/200/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h200)); end
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        total++; if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin bad++; $display("FAIL rdr_hold got=v%b/%b/%h want=v0/1/300", bus.if_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_timeout();
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_ready = 1'b0;
        for (int k = 1; k < MAX_WAIT; k++) tick();
        total++; if (bus.imem_req !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=req%b err%b want=req0 err0", bus.imem_req, bus.timeout_err); end
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300 || bus.timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_reissue got=%b/%h err%b want=1/300 err1", bus.imem_req, bus.imem_addr, bus.timeout_err); end
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'h300);
        tick();
        bus.imem_rvalid = 1'b0;
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h300 || bus.if_instr !== mem_word(32'h300)) begin bad++; $display("FAIL tmo_deliver got=%b/%h/%h want=1/300/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h300)); end
        tick();
        total++; if (bus.imem_addr !== 32'h304 || bus.timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%h err%b want=304 err1", bus.imem_addr, bus.timeout_err); end
    endtask

    task automatic test_wrap_misalign();
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || bus.misalign_err !== 1'b0) begin bad++; $display("FAIL wrap_redirect got=%b/%h mis%b want=1/fffffffc mis0", bus.imem_req, bus.imem_addr, bus.misalign_err); end
        bus.imem_ready = 1'b1;
        tick();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(32'hFFFF_FFFC);
        tick();
        bus.imem_rvalid = 1'b0;
        total++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_deliver got=%b/%h want=1/fffffffc", bus.if_valid, bus.if_pc); end
        tick();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_increment got=%b/%h want=1/0", bus.imem_req, bus.imem_addr); end
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        bus.redirect_valid = 1'b0;
        total++; if (bus.imem_addr !== 32'h100 || bus.misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_set got=%h mis%b want=100 mis1", bus.imem_addr, bus.misalign_err); end
        for (int k = 0; k < 3; k++) tick();
        total++; if (bus.misalign_err !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b want=1", bus.misalign_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.misalign_err !== 1'b0 || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL errs_cleared got=mis%b tmo%b want=00", bus.misalign_err, bus.timeout_err); end
    endtask

    // Random traffic. The model tracks the architectural fetch stream: the PC
    // that should be fetched next, whether an instruction is held for decode,
    // and whether the single in-flight response is still wanted.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic        exp_hold, exp_mis;
        logic        pend_valid, pend_stale;
        int          pend_cnt;
        logic [31:0] pend_data;
        logic        deliver, deliver_stale;
        int          delivered;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
        exp_pc     = 32'h0;
        exp_hold   = 1'b0;
        exp_mis    = 1'b0;
        pend_valid = 1'b0;
        pend_stale = 1'b0;
        pend_cnt   = 0;
        pend_data  = '0;
        delivered  = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.imem_req === 1'b1) begin
                total++; if (pend_valid) begin bad++; $display("FAIL rnd_one_outstanding cyc=%0d got=req while busy want=no req", cyc); end
                total++; if (bus.imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, bus.imem_addr, exp_pc); end
            end

            bus.stall          = ($urandom_range(0, 9) < 3);
            bus.redirect_valid = ($urandom_range(0, 99) < 6);
            bus.redirect_pc    = $urandom;
            if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
            bus.imem_ready     = ($urandom_range(0, 9) < 6);

            deliver       = 1'b0;
            deliver_stale = 1'b0;
            if (pend_valid && pend_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = pend_data;
                deliver         = 1'b1;
                deliver_stale   = pend_stale;
                pend_valid      = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
                if (pend_valid) pend_cnt--;
            end

            if (bus.imem_req === 1'b1 && bus.imem_ready) begin
                pend_valid = 1'b1;
                pend_stale = bus.redirect_valid;
                pend_cnt   = $urandom_range(0, 3);
                pend_data  = mem_word(bus.imem_addr);
            end else if (pend_valid && bus.redirect_valid) begin
                pend_stale = 1'b1;
            end

            if (exp_hold) begin
                if (bus.redirect_valid || !bus.stall) exp_hold = 1'b0;
                if (!bus.redirect_valid && !bus.stall) exp_pc = exp_pc + 32'd4;
            end else if (deliver && !deliver_stale && !bus.redirect_valid) begin
                exp_hold = 1'b1;
                delivered++;
            end
            if (bus.redirect_valid) begin
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
                if (bus.redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
            end

            tick();

            total++; if (bus.fetch_pc !== exp_pc) begin bad++; $display("FAIL rnd_fetch_pc cyc=%0d got=%h want=%h", cyc, bus.fetch_pc, exp_pc); end
            total++; if (bus.if_valid !== exp_hold) begin bad++; $display("FAIL rnd_if_valid cyc=%0d got=%b want=%b", cyc, bus.if_valid, exp_hold); end
            if (exp_hold) begin
                total++; if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h/%h want=%h/%h", cyc, bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc)); end
            end
            total++; if (bus.misalign_err !== exp_mis || bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rnd_errs cyc=%0d got=mis%b tmo%b want=mis%b tmo0", cyc, bus.misalign_err, bus.timeout_err, exp_mis); end
        end
        idle_inputs();
        total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress got=%0d want>=50", delivered); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid_hold();
        test_timeout();
        test_wrap_misalign();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
